// File: rtl/fadd_pkg.sv
// Shared definitions for the shared-adder arbiter: drain FSM encoding and default index width.
package fadd_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN      = 2'd1,
    DRAIN_DONE = 2'd2
  } fsm_state_e;

  localparam int NREQ_DFLT = 4;
  localparam int IDXW      = $clog2(NREQ_DFLT);

endpackage

// File: rtl/fadd_arbiter_rr_grant.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_grant
  import fadd_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT,
  parameter int IW   = IDXW
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // Scan from the farthest candidate back to ptr so the nearest request is the last write.
  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr_i) + off;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        any_o    = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined adder among NREQ slots with round-robin grant, tag return and drain FSM.
// Optional per-slot grant counters when FADD_ARB_PERF_EN is defined.
module fadd_arbiter
  import fadd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              busy
`ifdef FADD_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0] perf_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  fsm_state_e               state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [LAT-1:0]           tag_v_q, tag_v_d;
  logic [LAT-1:0][IW-1:0]   tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]          req_en_s;
  logic [NREQ-1:0]          gnt_s;
  logic [IW-1:0]            gnt_idx_s;
  logic                     gnt_any_s;
  logic                     drain_ok_s;

  // Gating with reset keeps req_ready quiet while reset is held, even with requests pending.
  assign req_en_s = req_valid & {NREQ{reset && (state_q == RUN)}};

  rr_grant #(.NREQ(NREQ), .IW(IW)) u_rr_grant (
    .req_i (req_en_s),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (gnt_idx_s),
    .any_o (gnt_any_s)
  );

  assign req_ready  = gnt_s;
  assign busy       = |tag_v_q;
  assign flush_done = (state_q == DRAIN_DONE);

  // Operand mux toward the adder; zero when idle.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (gnt_any_s) begin
      add_a = req_a[int'(gnt_idx_s)*W +: W];
      add_b = req_b[int'(gnt_idx_s)*W +: W];
    end else begin
      add_a = '0;
      add_b = '0;
    end
  end

  // Tag shift, pointer advance, and the "last op leaves this cycle" drain test.
  always_comb begin
    tag_v_d      = '0;
    tag_idx_d    = '0;
    tag_v_d[0]   = gnt_any_s;
    tag_idx_d[0] = gnt_idx_s;
    drain_ok_s   = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      tag_v_d[k]   = tag_v_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
    for (int k = 0; k < LAT - 1; k++) begin
      if (tag_v_q[k]) begin
        drain_ok_s = 1'b0;
      end else begin
        drain_ok_s = drain_ok_s;
      end
    end
    if (gnt_any_s) begin
      ptr_d = (gnt_idx_s == IW'(NREQ - 1)) ? '0 : gnt_idx_s + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Drain FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (flush_req) state_d = DRAIN;
        else           state_d = RUN;
      end
      DRAIN: begin
        if (drain_ok_s) state_d = DRAIN_DONE;
        else            state_d = DRAIN;
      end
      DRAIN_DONE: begin
        if (!flush_req) state_d = RUN;
        else            state_d = DRAIN_DONE;
      end
      default: state_d = RUN;
    endcase
  end

  // Response routing: the adder's registered sum passes through when the oldest tag is valid.
  always_comb begin
    rsp_valid = '0;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    if (tag_v_q[LAT-1]) begin
      rsp_valid[tag_idx_q[LAT-1]] = 1'b1;
      rsp_sum                     = add_sum;
      rsp_cout                    = add_cout;
    end else begin
      rsp_valid = '0;
      rsp_sum   = '0;
      rsp_cout  = 1'b0;
    end
  end

  // State, pointer and tag pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      tag_v_q   <= '0;
      tag_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tag_v_q   <= tag_v_d;
      tag_idx_q <= tag_idx_d;
    end
  end

`ifdef FADD_ARB_PERF_EN
  logic [NREQ-1:0][15:0] perf_q, perf_d;

  // Saturating per-slot grant counters, wiped when a drain completes.
  always_comb begin
    perf_d = perf_q;
    if ((state_d == DRAIN_DONE) && (state_q != DRAIN_DONE)) begin
      perf_d = '0;
    end else if (gnt_any_s && (perf_q[gnt_idx_s] != 16'hFFFF)) begin
      perf_d[gnt_idx_s] = perf_q[gnt_idx_s] + 16'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule
